muldiv_arbiter: RTL and testbench

//  Shares one uriscv_muldiv unit between NUM_REQ requesters (e.g. two issue ports or harts).

---
 rtl/muldiv_arbiter.sv | 146 ++++++++++++++
 tb/tb_muldiv_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_arbiter.sv
// Round-robin front end that shares one muldiv unit between NUM_REQ requesters.
// One op in flight; a watchdog turns a hung op into an error response.
module muldiv_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [3*NUM_REQ-1:0]   req_op_i,
  input  logic [32*NUM_REQ-1:0]  req_ra_i,
  input  logic [32*NUM_REQ-1:0]  req_rb_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [31:0]            rsp_data_o,
  output logic                   rsp_err_o,
  input  logic [NUM_REQ-1:0]     rsp_ready_i,
  output logic                   md_valid_o,
  output logic [7:0]             md_op_o,
  output logic [31:0]            md_ra_o,
  output logic [31:0]            md_rb_o,
  input  logic                   md_stall_i,
  input  logic                   md_ready_i,
  input  logic [31:0]            md_result_i,
  output logic                   busy_o
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYC);

  localparam logic [WDW-1:0]     WD_MAX = WDW'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0]     ID_MAX = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE    = NUM_REQ'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]     r_state;
  logic [IDW-1:0] r_rr;
  logic [IDW-1:0] r_id;
  logic [2:0]     r_op;
  logic [31:0]    r_ra;
  logic [31:0]    r_rb;
  logic [31:0]    r_res;
  logic           r_err;
  logic [WDW-1:0] r_wdog;

  logic           w_any;
  logic [IDW-1:0] w_gid;
  logic           w_idle;
  logic           w_issue;
  logic           w_resp;

  function automatic logic [IDW-1:0] rr_idx(
    input logic [IDW-1:0] base,
    input int             ofs
  );
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Scan farthest-first so the requester nearest rr_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[rr_idx(r_rr, i)]) begin
        w_any = 1'b1;
        w_gid = rr_idx(r_rr, i);
      end
    end
  end

  assign w_idle  = (r_state == S_IDLE);
  assign w_issue = (r_state == S_ISSUE) & ~md_stall_i;
  assign w_resp  = (r_state == S_RESP);

  assign req_ready_o = (rst_ni && w_idle && w_any) ? (ONE << w_gid) : '0;

  assign md_valid_o = w_issue;
  assign md_op_o    = w_issue ? (8'd1 << r_op) : 8'd0;
  assign md_ra_o    = w_issue ? r_ra : 32'd0;
  assign md_rb_o    = w_issue ? r_rb : 32'd0;

  assign rsp_valid_o = w_resp ? (ONE << r_id) : '0;
  assign rsp_data_o  = w_resp ? r_res : 32'd0;
  assign rsp_err_o   = w_resp & r_err;
  assign busy_o      = ~w_idle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_id    <= '0;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_wdog  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_gid;
            r_op    <= req_op_i[3*int'(w_gid) +: 3];
            r_ra    <= req_ra_i[32*int'(w_gid) +: 32];
            r_rb    <= req_rb_i[32*int'(w_gid) +: 32];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!md_stall_i) begin
            r_wdog  <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (md_ready_i) begin
            r_res   <= md_result_i;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_wdog == WD_MAX) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i[r_id]) begin
            r_rr    <= (r_id == ID_MAX) ? '0 : r_id + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed + randomized bench for muldiv_arbiter with an
// arithmetic muldiv reference and a round-robin grant model.
module tb_muldiv_arbiter;

  localparam int N  = 2;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_valid_i;
  logic [3*N-1:0] req_op_i;
  logic [32*N-1:0] req_ra_i;
  logic [32*N-1:0] req_rb_i;
  logic [N-1:0]  req_ready_o;
  logic [N-1:0]  rsp_valid_o;
  logic [31:0]   rsp_data_o;
  logic          rsp_err_o;
  logic [N-1:0]  rsp_ready_i;
  logic          md_valid_o;
  logic [7:0]    md_op_o;
  logic [31:0]   md_ra_o;
  logic [31:0]   md_rb_o;
  logic          md_stall_i;
  logic          md_ready_i;
  logic [31:0]   md_result_i;
  logic          busy_o;

  int total = 0;
  int bad   = 0;
  int nxt   = 0;

  logic [2:0]  op_a [N];
  logic [31:0] ra_a [N];
  logic [31:0] rb_a [N];

  always #5 clk = ~clk;

  muldiv_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_op_i    (req_op_i),
    .req_ra_i    (req_ra_i),
    .req_rb_i    (req_rb_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_ready_i (rsp_ready_i),
    .md_valid_o  (md_valid_o),
    .md_op_o     (md_op_o),
    .md_ra_o     (md_ra_o),
    .md_rb_o     (md_rb_o),
    .md_stall_i  (md_stall_i),
    .md_ready_i  (md_ready_i),
    .md_result_i (md_result_i),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin q = sa / sb; r = q[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic rnd_ops;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 3'($urandom_range(0, 7));
      ra_a[i] = $urandom;
      rb_a[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    end
  endtask

  task automatic drive_ops;
    req_op_i = {op_a[1], op_a[0]};
    req_ra_i = {ra_a[1], ra_a[0]};
    req_rb_i = {rb_a[1], rb_a[0]};
  endtask

  task automatic txn(input logic [1:0] vm, input int stall,
                     input int lat, input bit hang);
    int k;
    int c;
    logic [1:0]  kb;
    logic [31:0] exp_d;
    k = -1;
    for (int i = 0; i < N; i++) begin
      c = (nxt + i) % N;
      if (k < 0 && vm[c]) k = c;
    end
    kb    = 2'b01 << k;
    exp_d = hang ? 32'd0 : ref_md(op_a[k], ra_a[k], rb_a[k]);
    drive_ops();
    req_valid_i = vm;
    md_stall_i  = (stall > 0);
    #1;
    chk("grant", req_ready_o, kb);
    chk("idle_mdv", md_valid_o, 0);
    tick;
    req_valid_i = 2'b11;
    req_op_i    = 6'($urandom);
    req_ra_i    = {$urandom, $urandom};
    req_rb_i    = {$urandom, $urandom};
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_mdv", md_valid_o, 0);
      chk("stall_op", md_op_o, 0);
      chk("issue_rdy", req_ready_o, 0);
      tick;
    end
    md_stall_i = 1'b0;
    #1;
    chk("mdv", md_valid_o, 1);
    chk("mdop", md_op_o, 8'd1 << op_a[k]);
    chk("mdra", md_ra_o, ra_a[k]);
    chk("mdrb", md_rb_o, rb_a[k]);
    tick;
    if (hang) begin
      for (int i = 0; i < TO; i++) begin
        md_result_i = $urandom;
        #1;
        chk("wdog_rsp", rsp_valid_o, 0);
        chk("wdog_mdv", md_valid_o, 0);
        tick;
      end
    end else begin
      for (int i = 0; i < lat; i++) begin
        md_result_i = $urandom;
        #1;
        chk("wait_mdv", md_valid_o, 0);
        chk("wait_mdop", md_op_o, 0);
        tick;
      end
      md_ready_i  = 1'b1;
      md_result_i = exp_d;
      tick;
      md_ready_i  = 1'b0;
      md_result_i = ~exp_d;
    end
    req_valid_i = 2'b00;
    #1;
    chk("rsp_v", rsp_valid_o, kb);
    chk("rsp_d", rsp_data_o, exp_d);
    chk("rsp_e", rsp_err_o, hang);
    chk("rsp_busy", busy_o, 1);
    if (hang) begin
      md_ready_i  = 1'b1;
      md_result_i = 32'hDEAD_BEEF;
    end
    rsp_ready_i = ~kb;
    tick;
    md_ready_i = 1'b0;
    #1;
    chk("hold_v", rsp_valid_o, kb);
    chk("hold_d", rsp_data_o, exp_d);
    chk("hold_e", rsp_err_o, hang);
    rsp_ready_i = kb;
    tick;
    rsp_ready_i = 2'b00;
    #1;
    chk("done_v", rsp_valid_o, 0);
    chk("done_d", rsp_data_o, 0);
    chk("done_busy", busy_o, 0);
    nxt = (k + 1) % N;
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = 2'b11;
    req_op_i    = '0;
    req_ra_i    = '0;
    req_rb_i    = '0;
    rsp_ready_i = '0;
    md_stall_i  = 1'b0;
    md_ready_i  = 1'b0;
    md_result_i = '0;
    #2;
    chk("rst_rdy", req_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_mdv", md_valid_o, 0);
    chk("rst_rspv", rsp_valid_o, 0);
    chk("rst_err", rsp_err_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni      = 1'b1;
    req_valid_i = 2'b00;
    tick;

    // T1: MUL 7*6
    op_a[0] = 3'd0; ra_a[0] = 32'd7; rb_a[0] = 32'd6;
    txn(2'b01, 0, 2, 1'b0);

    // T2: both requesting, alternating grants
    for (int i = 0; i < 4; i++) begin
      rnd_ops();
      txn(2'b11, 0, $urandom_range(0, 3), 1'b0);
    end

    // T3: DIV overflow and REMU by zero from requester 1
    op_a[1] = 3'd4; ra_a[1] = 32'h8000_0000; rb_a[1] = 32'hFFFF_FFFF;
    txn(2'b10, 0, 1, 1'b0);
    op_a[1] = 3'd7; ra_a[1] = 32'd5; rb_a[1] = 32'd0;
    txn(2'b10, 0, 0, 1'b0);

    // T4: stall held in ISSUE
    rnd_ops();
    txn(2'b01, 5, 1, 1'b0);

    // T5: hung op aborted by watchdog
    rnd_ops();
    txn(2'b10, 0, 0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      rnd_ops();
      txn(2'($urandom_range(1, 3)), $urandom_range(0, 2),
          $urandom_range(0, 6), 1'b0);
    end

    // T6: reset during WAIT, rr pointer must return to 0
    rnd_ops();
    txn(2'b01, 0, 0, 1'b0);
    rnd_ops();
    drive_ops();
    req_valid_i = 2'b10;
    #1;
    chk("t6_grant", req_ready_o, 2'b10);
    tick;
    req_valid_i = 2'b00;
    tick;
    #1;
    chk("t6_busy", busy_o, 1);
    rst_ni      = 1'b0;
    req_valid_i = 2'b11;
    #1;
    chk("t6_rdy", req_ready_o, 0);
    chk("t6_busy0", busy_o, 0);
    chk("t6_mdv", md_valid_o, 0);
    chk("t6_rspv", rsp_valid_o, 0);
    chk("t6_data", rsp_data_o, 0);
    tick;
    rst_ni      = 1'b1;
    req_valid_i = 2'b00;
    nxt         = 0;
    tick;
    rnd_ops();
    txn(2'b11, 0, 1, 1'b0);
    rnd_ops();
    txn(2'b10, 0, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
